// File: rtl/updown_round_ctrl.sv
// Round controller for the up/down guessing game: counts attempts, narrows the
// [lo,hi] hint window, decides win/lose and requests a fresh secret each round.
module updown_round_ctrl #(
  parameter int MAX_ATTEMPTS = 7,
  parameter int MIN_VAL      = 1,
  parameter int MAX_VAL      = 100,
  parameter int END_HOLD     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       result_valid,
  input  logic [6:0] guess_number,
  input  logic [1:0] comparison_result,
  output logic       new_round,
  output logic [1:0] game_state,
  output logic [3:0] attempts,
  output logic [6:0] range_lo,
  output logic [6:0] range_hi,
  output logic [1:0] hint,
  output logic       win,
  output logic       lose
);

  // Upstream handshake: result_valid is a 1-cycle qualifier with no back-pressure.
  // guess_number/comparison_result are consumed on the edge where it is high, only in PLAY.
  // start outranks result_valid on the same edge, and the guess is dropped.

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  localparam int              HOLD_W    = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(END_HOLD - 1);
  localparam logic [3:0]      ATT_MAX   = 4'(MAX_ATTEMPTS);
  localparam logic [6:0]      LO_INIT   = 7'(MIN_VAL);
  localparam logic [6:0]      HI_INIT   = 7'(MAX_VAL);

  state_t            r_state, w_state;
  logic [3:0]        r_attempts, w_attempts;
  logic [6:0]        r_lo, w_lo;
  logic [6:0]        r_hi, w_hi;
  logic [1:0]        r_hint, w_hint;
  logic              r_new_round, w_new_round;
  logic              r_win, w_win;
  logic              r_lose, w_lose;
  logic [HOLD_W-1:0] r_hold, w_hold;

  logic [3:0]        w_att_p1;
  logic [6:0]        w_guess_p1;
  logic [6:0]        w_guess_m1;

  assign w_att_p1   = r_attempts + 4'd1;
  assign w_guess_p1 = guess_number + 7'd1;
  assign w_guess_m1 = guess_number - 7'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_attempts  <= 4'd0;
      r_lo        <= LO_INIT;
      r_hi        <= HI_INIT;
      r_hint      <= 2'b00;
      r_new_round <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state;
      r_attempts  <= w_attempts;
      r_lo        <= w_lo;
      r_hi        <= w_hi;
      r_hint      <= w_hint;
      r_new_round <= w_new_round;
      r_win       <= w_win;
      r_lose      <= w_lose;
      r_hold      <= w_hold;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_attempts  = r_attempts;
    w_lo        = r_lo;
    w_hi        = r_hi;
    w_hint      = r_hint;
    w_new_round = 1'b0;
    w_hold      = r_hold;

    if (start) begin
      w_state     = ST_PLAY;
      w_attempts  = 4'd0;
      w_lo        = LO_INIT;
      w_hi        = HI_INIT;
      w_hint      = 2'b00;
      w_new_round = 1'b1;
      w_hold      = '0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (result_valid) begin
            case (comparison_result)
              2'b01: begin
                w_attempts = w_att_p1;
                w_hint     = 2'b01;
                // Window only ever narrows; out-of-window guesses still cost an attempt.
                if (guess_number >= r_lo) w_lo = w_guess_p1;
                if (w_att_p1 == ATT_MAX) begin
                  w_state = ST_LOSE;
                  w_hold  = '0;
                end
              end
              2'b10: begin
                w_attempts = w_att_p1;
                w_hint     = 2'b10;
                if (guess_number <= r_hi) w_hi = w_guess_m1;
                if (w_att_p1 == ATT_MAX) begin
                  w_state = ST_LOSE;
                  w_hold  = '0;
                end
              end
              2'b11: begin
                w_attempts = w_att_p1;
                w_hint     = 2'b11;
                w_lo       = guess_number;
                w_hi       = guess_number;
                w_state    = ST_WIN;
                w_hold     = '0;
              end
              default: ;
            endcase
          end
        end
        ST_WIN, ST_LOSE: begin
          if (r_hold == HOLD_LAST) begin
            w_state = ST_IDLE;
            w_hold  = '0;
          end else begin
            w_hold = r_hold + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end

    w_win  = (w_state == ST_WIN);
    w_lose = (w_state == ST_LOSE);
  end

  assign new_round  = r_new_round;
  assign game_state = r_state;
  assign attempts   = r_attempts;
  assign range_lo   = r_lo;
  assign range_hi   = r_hi;
  assign hint       = r_hint;
  assign win        = r_win;
  assign lose       = r_lose;

endmodule

// File: tb/tb_updown_round_ctrl.sv
// Directed bench for updown_round_ctrl with hand-computed expected vectors.
module tb_updown_round_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       result_valid;
  logic [6:0] guess_number;
  logic [1:0] comparison_result;
  logic       new_round;
  logic [1:0] game_state;
  logic [3:0] attempts;
  logic [6:0] range_lo;
  logic [6:0] range_hi;
  logic [1:0] hint;
  logic       win;
  logic       lose;

  int total = 0;
  int bad   = 0;

  logic [24:0] obs;
  logic [24:0] ev;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_WIN  = 2'b10;
  localparam logic [1:0] S_LOSE = 2'b11;

  updown_round_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .result_valid      (result_valid),
    .guess_number      (guess_number),
    .comparison_result (comparison_result),
    .new_round         (new_round),
    .game_state        (game_state),
    .attempts          (attempts),
    .range_lo          (range_lo),
    .range_hi          (range_hi),
    .hint,
    .win               (win),
    .lose              (lose)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // observed vector: {state, attempts, lo, hi, hint, new_round, win, lose}
  assign obs = {game_state, attempts, range_lo, range_hi, hint, new_round, win, lose};

  function automatic logic [24:0] exp_vec(input logic [1:0] st, input int att, input int lo,
                                          input int hi, input logic [1:0] h, input logic nr);
    return {st, 4'(att), 7'(lo), 7'(hi), h, nr, (st == S_WIN), (st == S_LOSE)};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic guess(input logic [6:0] g, input logic [1:0] r);
    guess_number      = g;
    comparison_result = r;
    result_valid      = 1'b1;
    tick();
    result_valid      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; result_valid = 1'b0;
    guess_number = 7'd0; comparison_result = 2'b00;
    #1;
    ev = exp_vec(S_IDLE, 0, 1, 100, 2'b00, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, ev); end
    tick(); tick();
    reset = 1'b0;
    tick();
    ev = exp_vec(S_IDLE, 0, 1, 100, 2'b00, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_start();
    pulse_start();
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b1); total++;
    if (obs !== ev) begin bad++; $display("FAIL start_init got=%b exp=%b", obs, ev); end
    tick();
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL start_pulse_end got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_win_round();
    guess(7'd50, 2'b01);
    ev = exp_vec(S_PLAY, 1, 51, 100, 2'b01, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL win_up50 got=%b exp=%b", obs, ev); end
    guess(7'd75, 2'b10);
    ev = exp_vec(S_PLAY, 2, 51, 74, 2'b10, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL win_down75 got=%b exp=%b", obs, ev); end
    guess(7'd62, 2'b11);
    ev = exp_vec(S_WIN, 3, 62, 62, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL win_hit62 got=%b exp=%b", obs, ev); end
    // 199 more cycles in WIN, with a stray guess that must be ignored
    for (int i = 0; i < 199; i++) begin
      if (i == 5) begin
        guess_number = 7'd30; comparison_result = 2'b01; result_valid = 1'b1;
      end
      tick();
      result_valid = 1'b0;
    end
    ev = exp_vec(S_WIN, 3, 62, 62, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL win_hold_199 got=%b exp=%b", obs, ev); end
    tick();
    ev = exp_vec(S_IDLE, 3, 62, 62, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL win_to_idle got=%b exp=%b", obs, ev); end
    guess(7'd10, 2'b01);
    ev = exp_vec(S_IDLE, 3, 62, 62, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL idle_ignores_guess got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_lose();
    pulse_start();
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b1); total++;
    if (obs !== ev) begin bad++; $display("FAIL lose_init got=%b exp=%b", obs, ev); end
    for (int i = 1; i <= 6; i++) begin
      guess(7'(10 * i), 2'b01);
      ev = exp_vec(S_PLAY, i, 10 * i + 1, 100, 2'b01, 1'b0); total++;
      if (obs !== ev) begin bad++; $display("FAIL lose_up%0d got=%b exp=%b", i, obs, ev); end
    end
    guess(7'd70, 2'b01);
    ev = exp_vec(S_LOSE, 7, 71, 100, 2'b01, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL lose_7th got=%b exp=%b", obs, ev); end
    guess(7'd80, 2'b10);
    ev = exp_vec(S_LOSE, 7, 71, 100, 2'b01, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL lose_ignores got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_win_on_last();
    pulse_start();
    for (int i = 1; i <= 6; i++) guess(7'(5 * i), 2'b01);
    ev = exp_vec(S_PLAY, 6, 31, 100, 2'b01, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL last_pre got=%b exp=%b", obs, ev); end
    guess(7'd40, 2'b11);
    ev = exp_vec(S_WIN, 7, 40, 40, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL last_win got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_out_of_window();
    pulse_start();
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b1); total++;
    if (obs !== ev) begin bad++; $display("FAIL oow_restart got=%b exp=%b", obs, ev); end
    guess(7'd50, 2'b01);
    guess(7'd20, 2'b01);
    ev = exp_vec(S_PLAY, 2, 51, 100, 2'b01, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL oow_up20 got=%b exp=%b", obs, ev); end
    guess(7'd90, 2'b10);
    ev = exp_vec(S_PLAY, 3, 51, 89, 2'b10, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL oow_down90 got=%b exp=%b", obs, ev); end
    guess(7'd95, 2'b10);
    ev = exp_vec(S_PLAY, 4, 51, 89, 2'b10, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL oow_down95 got=%b exp=%b", obs, ev); end
    guess(7'd33, 2'b00);
    ev = exp_vec(S_PLAY, 4, 51, 89, 2'b10, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL oow_none got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_start_priority();
    start = 1'b1; result_valid = 1'b1; guess_number = 7'd50; comparison_result = 2'b11;
    tick();
    start = 1'b0; result_valid = 1'b0;
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b1); total++;
    if (obs !== ev) begin bad++; $display("FAIL prio_start got=%b exp=%b", obs, ev); end
    guess(7'd40, 2'b11);
    tick(); tick(); tick();
    ev = exp_vec(S_WIN, 1, 40, 40, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL prio_win got=%b exp=%b", obs, ev); end
    pulse_start();
    ev = exp_vec(S_PLAY, 0, 1, 100, 2'b00, 1'b1); total++;
    if (obs !== ev) begin bad++; $display("FAIL hold_restart got=%b exp=%b", obs, ev); end
    guess(7'd41, 2'b11);
    for (int i = 0; i < 199; i++) tick();
    ev = exp_vec(S_WIN, 1, 41, 41, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL rewin_hold got=%b exp=%b", obs, ev); end
    tick();
    ev = exp_vec(S_IDLE, 1, 41, 41, 2'b11, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL rewin_idle got=%b exp=%b", obs, ev); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    guess(7'd50, 2'b01);
    #3;
    reset = 1'b1;
    #1;
    ev = exp_vec(S_IDLE, 0, 1, 100, 2'b00, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL async_reset got=%b exp=%b", obs, ev); end
    tick();
    reset = 1'b0;
    tick();
    ev = exp_vec(S_IDLE, 0, 1, 100, 2'b00, 1'b0); total++;
    if (obs !== ev) begin bad++; $display("FAIL reset_no_pulse got=%b exp=%b", obs, ev); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win_round();
    test_lose();
    test_win_on_last();
    test_out_of_window();
    test_start_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
